// File: rtl/fanout_fork_pkg.sv
// Purpose: shared types and default sizing for the fanout fork.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fanout_fork_pkg;

  // Fork discipline: LAZY offers a token only when every active branch is
  // ready; EAGER lets each branch take it as soon as that branch is ready.
  typedef enum logic {
    LAZY  = 1'b0,
    EAGER = 1'b1
  } fork_mode_e;

  localparam int DEF_NUM_CH = 9;
  localparam int DEF_DATA_W = 17;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/fanout_fork_ch.sv
// Purpose: one fork branch; active mask, branch valid, ready term, served flag.
// Latency: combinational valid/ready; served flag updates on the next enabled edge.
// Backpressure: a not-ready active branch pulls its ready term low, stalling upstream.
//
// Ports: clk/rst_n/clk_en/flush control the served flag; en/sel form the
// branch activity; mode picks LAZY/EAGER; in_valid, all_rdy and accept come
// from the top; out_ready/out_valid are this branch's handshake; rdy_term is
// this branch's contribution to the upstream ready AND-reduction.
module fanout_fork_ch
  import fanout_fork_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       flush,
  input  logic       en,
  input  logic       sel,
  input  fork_mode_e mode,
  input  logic       in_valid,
  input  logic       all_rdy,
  input  logic       accept,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       rdy_term
);

  logic act;
  logic done;
  logic done_eff;
  logic fire;

  assign act = en & sel;

  // A stale served flag left over from EAGER must not count while in LAZY;
  // it is cleared on the next enabled edge anyway.
  assign done_eff = (mode == EAGER) & done;

  // Inactive branches never block; a served branch no longer needs ready.
  assign rdy_term = ~act | done_eff | out_ready;

  always_comb begin
    out_valid = 1'b0;
    if (rst_n) begin
      if (mode == EAGER) out_valid = in_valid & act & ~done;
      else               out_valid = in_valid & act & all_rdy;
    end
  end

  assign fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (clk_en) begin
      if (flush || accept || (mode == LAZY)) done <= 1'b0;
      else                                   done <= done | fire;
    end
  end

endmodule

// File: rtl/fanout_fork.sv
// Purpose: broadcast one upstream stream to NUM_CH branches, counting accepted tokens.
// Latency: zero-cycle data/valid/ready path; token counter updates on the accept edge.
// Backpressure: upstream ready only when every active branch has taken or can take the token.
//
// Ports: clk, rst_n (sync, active-low), clk_en (global hold), flush (clear
// fork state and counter); cfg_en/cfg_sel/cfg_mode select branches and
// discipline; in_data/in_valid/in_ready upstream; out_data/out_valid/out_ready
// downstream; tok_cnt saturating count of accepted tokens.
module fanout_fork
  import fanout_fork_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [NUM_CH-1:0] cfg_en,
  input  logic [NUM_CH-1:0] cfg_sel,
  input  logic              cfg_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  tok_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fork_mode_e        mode;
  logic [NUM_CH-1:0] rdy_term;
  logic              all_rdy;
  logic              accept;

  assign mode     = fork_mode_e'(cfg_mode);
  assign out_data = in_data;

  // With no active branch the AND-reduction is 1, so tokens drain and are counted.
  assign all_rdy  = &rdy_term;
  assign in_ready = rst_n & all_rdy;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fanout_fork_ch u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_en    (clk_en),
      .flush     (flush),
      .en        (cfg_en[i]),
      .sel       (cfg_sel[i]),
      .mode      (mode),
      .in_valid  (in_valid),
      .all_rdy   (all_rdy),
      .accept    (accept),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .rdy_term  (rdy_term[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok_cnt <= '0;
    end else if (clk_en) begin
      if (flush)                              tok_cnt <= '0;
      else if (accept && (tok_cnt != CNT_MAX)) tok_cnt <= tok_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fanout_fork.sv
// Purpose: self-checking bench for fanout_fork (default sizing plus a 4-bit counter copy).
// Latency: checks combinational outputs mid-cycle, state after each rising edge.
// Backpressure: branch ready driven from tables, hand sequences and random draws.
module tb_fanout_fork;

  localparam int NUM_CH = 9;
  localparam int DATA_W = 17;

  logic              clk;
  logic              rst_n;
  logic              clk_en;
  logic              flush;
  logic [NUM_CH-1:0] cfg_en;
  logic [NUM_CH-1:0] cfg_sel;
  logic              cfg_mode;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [NUM_CH-1:0] out_ready;

  logic              in_ready,  in_ready4;
  logic [DATA_W-1:0] out_data,  out_data4;
  logic [NUM_CH-1:0] out_valid, out_valid4;
  logic [15:0]       tok_cnt;
  logic [3:0]        tok_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: which branches have already taken the current token,
  // plus the two token counts.
  logic [NUM_CH-1:0] m_served = '0;
  int                m_cnt    = 0;
  int                m_cnt4   = 0;

  fanout_fork #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .cfg_en(cfg_en), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tok_cnt(tok_cnt)
  );

  fanout_fork #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .cfg_en(cfg_en), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .tok_cnt(tok_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Expected outputs from the fork rules, viewed as sets of branches.
  task automatic model_eval(output logic [NUM_CH-1:0] ev, output logic er);
    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] pending;
    act = cfg_en & cfg_sel;
    ev  = '0;
    er  = 1'b0;
    if (rst_n) begin
      if (cfg_mode) begin
        pending = act & ~m_served;
        er = ((pending & ~out_ready) == '0);
        ev = in_valid ? pending : '0;
      end else begin
        er = ((act & ~out_ready) == '0);
        ev = (in_valid && er) ? act : '0;
      end
    end
  endtask

  task automatic model_update();
    logic [NUM_CH-1:0] ev;
    logic              er;
    model_eval(ev, er);
    if (!rst_n) begin
      m_served = '0; m_cnt = 0; m_cnt4 = 0;
    end else if (clk_en) begin
      if (flush) begin
        m_served = '0; m_cnt = 0; m_cnt4 = 0;
      end else if (in_valid && er) begin
        m_served = '0;
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt4 < 15)    m_cnt4++;
      end else if (!cfg_mode) begin
        m_served = '0;
      end else begin
        m_served = m_served | (ev & out_ready);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [NUM_CH-1:0] ev;
    logic              er;
    model_eval(ev, er);
    chk({tag, ".in_ready"},   32'(in_ready),   32'(er));
    chk({tag, ".out_valid"},  32'(out_valid),  32'(ev));
    chk({tag, ".out_data"},   32'(out_data),   32'(in_data));
    chk({tag, ".tok_cnt"},    32'(tok_cnt),    32'(m_cnt));
    chk({tag, ".tok_cnt4"},   32'(tok_cnt4),   32'(m_cnt4));
    chk({tag, ".in_ready4"},  32'(in_ready4),  32'(er));
    chk({tag, ".out_valid4"}, 32'(out_valid4), 32'(ev));
    chk({tag, ".out_data4"},  32'(out_data4),  32'(in_data));
  endtask

  // Inputs are driven 1 time unit after a rising edge; settle moves to the
  // falling edge for sampling, advance steps the model then crosses the edge.
  task automatic settle();
    #4;
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0; out_ready = '0;
    settle(); advance();
    flush = 1'b0;
  endtask

  task automatic set_cfg(input logic mode, input logic [NUM_CH-1:0] act);
    cfg_mode = mode; cfg_en = '1; cfg_sel = act;
  endtask

  typedef struct {
    logic              mode;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] sel;
    logic              iv;
    logic [NUM_CH-1:0] ordy;
    logic [NUM_CH-1:0] ev;
    logic              er;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 9'h1FF, 9'h1FF, 1'b1, 9'h1FF, 9'h1FF, 1'b1};
    tbl[1] = '{1'b1, 9'h1FF, 9'h1FF, 1'b1, 9'h0FF, 9'h1FF, 1'b0};
    tbl[2] = '{1'b1, 9'h00F, 9'h0F0, 1'b1, 9'h000, 9'h000, 1'b1};
    tbl[3] = '{1'b1, 9'h0F0, 9'h0F0, 1'b0, 9'h0F0, 9'h000, 1'b1};
    tbl[4] = '{1'b0, 9'h1FF, 9'h003, 1'b1, 9'h001, 9'h000, 1'b0};
    tbl[5] = '{1'b0, 9'h1FF, 9'h003, 1'b1, 9'h003, 9'h003, 1'b1};
    tbl[6] = '{1'b0, 9'h1FF, 9'h101, 1'b1, 9'h1FE, 9'h000, 1'b0};
    tbl[7] = '{1'b1, 9'h101, 9'h1FF, 1'b1, 9'h100, 9'h101, 1'b0};
    tbl[8] = '{1'b0, 9'h055, 9'h0FF, 1'b1, 9'h055, 9'h055, 1'b1};
    tbl[9] = '{1'b0, 9'h1FF, 9'h1FF, 1'b0, 9'h1FF, 9'h000, 1'b1};

    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
    cfg_en = '1; cfg_sel = '1; cfg_mode = 1'b1;
    in_data = 17'h1A5A5; in_valid = 1'b1; out_ready = '1;

    // Reset: outputs blocked, data still flows through, counters clear.
    @(posedge clk); #1;
    settle();
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'h1A5A5);
    chk("rst.tok_cnt",   32'(tok_cnt),   32'd0);
    advance();
    rst_n = 1'b1;
    do_flush();

    // Combinational vectors; flush on each keeps state clear between rows.
    for (int k = 0; k < 10; k++) begin
      cfg_mode = tbl[k].mode; cfg_en = tbl[k].en; cfg_sel = tbl[k].sel;
      in_valid = tbl[k].iv; out_ready = tbl[k].ordy;
      in_data = DATA_W'($urandom);
      flush = 1'b1;
      settle();
      chk($sformatf("vec%0d.out_valid", k), 32'(out_valid), 32'(tbl[k].ev));
      chk($sformatf("vec%0d.in_ready", k),  32'(in_ready),  32'(tbl[k].er));
      chk($sformatf("vec%0d.out_data", k),  32'(out_data),  32'(in_data));
      advance();
    end
    flush = 1'b0;
    chk("vec.tok_cnt", 32'(tok_cnt), 32'd0);

    // EAGER staggered readiness: one fire per branch, accept in the third cycle.
    do_flush();
    set_cfg(1'b1, 9'h007); in_valid = 1'b1;
    out_ready = 9'h001; settle();
    chk("eag.c1.valid", 32'(out_valid), 32'h007); chk("eag.c1.ready", 32'(in_ready), 32'd0); advance();
    out_ready = 9'h002; settle();
    chk("eag.c2.valid", 32'(out_valid), 32'h006); chk("eag.c2.ready", 32'(in_ready), 32'd0); advance();
    out_ready = 9'h004; settle();
    chk("eag.c3.valid", 32'(out_valid), 32'h004); chk("eag.c3.ready", 32'(in_ready), 32'd1); advance();
    in_valid = 1'b0; out_ready = '0; settle();
    chk("eag.tok_cnt", 32'(tok_cnt), 32'd1);

    // LAZY: nothing offered until both active branches are ready together.
    do_flush();
    set_cfg(1'b0, 9'h003); in_valid = 1'b1; out_ready = 9'h001;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("lazy.c%0d.valid", c + 1), 32'(out_valid), 32'd0);
      chk($sformatf("lazy.c%0d.ready", c + 1), 32'(in_ready),  32'd0);
      advance();
    end
    out_ready = 9'h003; settle();
    chk("lazy.c5.valid", 32'(out_valid), 32'h003); chk("lazy.c5.ready", 32'(in_ready), 32'd1); advance();
    in_valid = 1'b0; settle();
    chk("lazy.tok_cnt", 32'(tok_cnt), 32'd1);

    // All branches inactive: tokens drain and are counted.
    do_flush();
    set_cfg(1'b1, 9'h000); in_valid = 1'b1; out_ready = '0;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("idle.c%0d.ready", c), 32'(in_ready),  32'd1);
      chk($sformatf("idle.c%0d.valid", c), 32'(out_valid), 32'd0);
      advance();
    end
    in_valid = 1'b0; settle();
    chk("idle.tok_cnt", 32'(tok_cnt), 32'd10);

    // Reset mid-token: partial delivery discarded, token re-offered to b0.
    do_flush();
    set_cfg(1'b1, 9'h003); in_valid = 1'b1; out_ready = 9'h003;
    settle(); advance();
    out_ready = 9'h001; settle();
    chk("rmt.c1.valid", 32'(out_valid), 32'h003); advance();
    out_ready = 9'h000; settle();
    chk("rmt.c2.valid", 32'(out_valid), 32'h002); chk("rmt.cnt_pre", 32'(tok_cnt), 32'd1); advance();
    rst_n = 1'b0; settle();
    chk("rmt.rst.valid", 32'(out_valid), 32'd0); chk("rmt.rst.ready", 32'(in_ready), 32'd0); advance();
    rst_n = 1'b1; settle();
    chk("rmt.after.valid", 32'(out_valid), 32'h003); chk("rmt.after.tok_cnt", 32'(tok_cnt), 32'd0); advance();

    // 4-bit counter saturation, then flush (wins over a concurrent accept).
    do_flush();
    set_cfg(1'b1, 9'h000); in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      settle(); advance();
    end
    settle();
    chk("sat.tok_cnt4", 32'(tok_cnt4), 32'd15);
    chk("sat.tok_cnt",  32'(tok_cnt),  32'd20);
    flush = 1'b1;
    chk("sat.flush.ready", 32'(in_ready), 32'd1);
    advance();
    flush = 1'b0; in_valid = 1'b0; settle();
    chk("sat.flush.tok_cnt4", 32'(tok_cnt4), 32'd0);
    chk("sat.flush.tok_cnt",  32'(tok_cnt),  32'd0);
    advance();

    // clk_en low during partial EAGER delivery: served flag and count hold.
    do_flush();
    set_cfg(1'b1, 9'h003); in_valid = 1'b1; out_ready = 9'h001;
    settle(); advance();
    clk_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("cke.c%0d.valid", c), 32'(out_valid), 32'h002);
      chk($sformatf("cke.c%0d.ready", c), 32'(in_ready),  32'd0);
      advance();
    end
    clk_en = 1'b1; settle();
    chk("cke.resume.valid", 32'(out_valid), 32'h002); chk("cke.resume.tok", 32'(tok_cnt), 32'd0); advance();
    out_ready = 9'h002; settle();
    chk("cke.last.ready", 32'(in_ready), 32'd1); advance();
    in_valid = 1'b0; settle();
    chk("cke.tok_cnt", 32'(tok_cnt), 32'd1);
    advance();

    // EAGER -> LAZY clears served flags, so the token is offered to b0 again.
    do_flush();
    set_cfg(1'b1, 9'h003); in_valid = 1'b1; out_ready = 9'h001;
    settle(); advance();
    cfg_mode = 1'b0; in_valid = 1'b0; out_ready = '0;
    settle(); advance();
    cfg_mode = 1'b1; in_valid = 1'b1; settle();
    chk("mode.valid", 32'(out_valid), 32'h003);
    advance();

    // Randomised traffic against the reference model.
    do_flush();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_en  = NUM_CH'($urandom);
        cfg_sel = NUM_CH'($urandom) | NUM_CH'($urandom);
      end
      if ($urandom_range(0, 29) == 0) cfg_mode = ~cfg_mode;
      clk_en    = ($urandom_range(0, 9)  != 0);
      flush     = ($urandom_range(0, 59) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3)  != 0);
      in_data   = DATA_W'($urandom);
      out_ready = NUM_CH'($urandom) | NUM_CH'($urandom);
      settle();
      check_model($sformatf("rnd%0d", c));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fanout_fork.md
FANOUT_FORK -- requirements
Module: fanout_fork

Interface
REQ-001 Parameter NUM_CH, default 9: number of downstream fanout branches, legal range 1..16.
REQ-002 Parameter DATA_W, default 17: payload width.
REQ-003 Parameter CNT_W, default 16: width of the token counter.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 clk_en  in  1  state-update enable; when 0 all registers hold.
REQ-007 flush  in  1  synchronous clear of fork state and counter.
REQ-008 cfg_en  in  NUM_CH  per-branch enable.
REQ-009 cfg_sel  in  NUM_CH  per-branch route select.
REQ-010 cfg_mode  in  1  0 = LAZY fork, 1 = EAGER fork.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 in_valid  in  1  upstream valid.
REQ-013 in_ready  out  1  upstream ready.
REQ-014 out_data  out  DATA_W  payload broadcast to all branches.
REQ-015 out_valid  out  NUM_CH  per-branch valid.
REQ-016 out_ready  in  NUM_CH  per-branch ready.
REQ-017 tok_cnt  out  CNT_W  count of upstream tokens consumed.

Function
REQ-018 Active mask act[i] = cfg_en[i] & cfg_sel[i]; an inactive branch never asserts out_valid and never blocks in_ready.
REQ-019 out_data equals in_data, combinational, zero latency.
REQ-020 Per-branch register done[i] marks that branch i has taken the current token.
REQ-021 EAGER: out_valid[i] = in_valid & act[i] & ~done[i].
REQ-022 EAGER: branch fire[i] = out_valid[i] & out_ready[i].
REQ-023 EAGER: in_ready = AND over i of (~act[i] | done[i] | out_ready[i]).
REQ-024 LAZY: out_valid[i] = in_valid & act[i] & AND over j of (~act[j] | out_ready[j]).
REQ-025 LAZY: done[] remains 0.
REQ-026 LAZY: in_ready uses the REQ-023 expression with done = 0, so all active branches fire in the same cycle.
REQ-027 Upstream accept = in_valid & in_ready.
REQ-028 On accept (clk_en=1): done[] <= 0 and tok_cnt increments by 1.
REQ-029 Without accept (clk_en=1, EAGER): done[i] <= done[i] | fire[i].
REQ-030 tok_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-031 All-inactive mask (act = 0): in_ready = 1, no out_valid asserted, and accepted tokens are dropped but still counted.
REQ-032 Mask or mode change mid-token is legal: done[] bits of now-inactive branches are ignored, and a branch becoming active with done[i]=1 is treated as served.
REQ-033 Switching cfg_mode from 1 to 0 clears done[] on the next enabled edge.
REQ-034 flush=1 (clk_en=1) clears done[] and tok_cnt and takes priority over accept; in_ready and out_valid are still evaluated combinationally that cycle.
REQ-035 A token is never delivered twice to the same branch and never skipped by an active branch.

Reset
REQ-036 rst_n=0 at a rising edge clears done[] to 0 and tok_cnt to 0, regardless of clk_en.
REQ-037 While rst_n=0, in_ready=0 and out_valid=0 on all branches, and out_data still follows in_data.
REQ-038 Reset mid-token discards partial delivery, so after reset the token is re-offered to all active branches.

Structure
REQ-039 A shared package holds the fork-mode enum (LAZY=0, EAGER=1) and defaults NUM_CH=9, DATA_W=17, CNT_W=16.
REQ-040 A single per-branch sub-module fanout_fork_ch computes act, out_valid, fire, the ready term and the done register, and is instantiated NUM_CH times.
REQ-041 The top level contains only the AND-reduction, accept logic and counter.

Verification
REQ-042 EAGER, act=9'h007, in_valid=1 held, out_ready staggered (b0 cycle 1, b1 cycle 2, b2 cycle 3) -> each branch fires exactly once, in_ready=1 only in cycle 3, tok_cnt=1.
REQ-043 LAZY, act=9'h003, out_ready=2'b01 for 4 cycles then 2'b11 -> out_valid=0 for 4 cycles, both branches valid and in_ready=1 in cycle 5, tok_cnt=1.
REQ-044 act=0, in_valid=1 for 10 cycles -> in_ready=1 throughout, out_valid=0, tok_cnt=10.
REQ-045 EAGER, b0 fired and b1 pending, then rst_n=0 for 1 cycle -> done cleared, b0 re-offered the same token, tok_cnt=0.
REQ-046 CNT_W=4, 20 back-to-back accepts -> tok_cnt stops at 15; flush=1 -> tok_cnt=0 next cycle.
REQ-047 clk_en=0 during a partial EAGER delivery -> done[] and tok_cnt hold, no duplicate fire after clk_en returns to 1.
